// File: rtl/mips_pkg.sv
// Shared ISA constants for the data-memory path: load/store opcodes, lane geometry,
// the access FSM state type and small opcode decode helpers.
package mips_pkg;

    localparam int BYTE_W = 8;
    localparam int LANES  = 4;

    localparam logic [5:0] OPCODE_LB  = 6'h20;
    localparam logic [5:0] OPCODE_LH  = 6'h21;
    localparam logic [5:0] OPCODE_LWL = 6'h22;
    localparam logic [5:0] OPCODE_LW  = 6'h23;
    localparam logic [5:0] OPCODE_LBU = 6'h24;
    localparam logic [5:0] OPCODE_LHU = 6'h25;
    localparam logic [5:0] OPCODE_LWR = 6'h26;
    localparam logic [5:0] OPCODE_SB  = 6'h28;
    localparam logic [5:0] OPCODE_SH  = 6'h29;
    localparam logic [5:0] OPCODE_SW  = 6'h2B;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_DONE   = 2'd2
    } mem_state_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        case (op)
            OPCODE_LB, OPCODE_LH, OPCODE_LWL, OPCODE_LW, OPCODE_LBU,
            OPCODE_LHU, OPCODE_LWR, OPCODE_SB, OPCODE_SH, OPCODE_SW: is_mem_op = 1'b1;
            default:                                                 is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        is_store = (op == OPCODE_SB) || (op == OPCODE_SH) || (op == OPCODE_SW);
    endfunction

    function automatic logic [LANES-1:0] lane_enable(input logic [5:0] op, input logic [1:0] off);
        case (op)
            OPCODE_LB, OPCODE_LBU, OPCODE_SB: lane_enable = 4'b0001 << off;
            OPCODE_LH, OPCODE_LHU, OPCODE_SH: lane_enable = off[1] ? 4'b1100 : 4'b0011;
            default:                          lane_enable = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [5:0] op, input logic [31:0] data);
        case (op)
            OPCODE_SB: store_lanes = {4{data[7:0]}};
            OPCODE_SH: store_lanes = {2{data[15:0]}};
            default:   store_lanes = data;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_controller_if.sv
// Avalon-MM data-port bundle between the memory access controller (master) and memory (slave).
interface mem_access_controller_if;

    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
        output avm_readdata, avm_waitrequest
    );

endinterface

// File: rtl/mem_access_controller_load_extend.sv
// Load write-back formatting: lane select, sign/zero extension and LWL/LWR merge with old rt.
module load_extend
    import mips_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [5:0]  opcode,
    input  logic [31:0] rt_old,
    output logic [31:0] result
);

    logic [4:0]  shift;
    logic [4:0]  shift_left;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        shift      = {off, 3'b000};
        shift_left = {2'd3 - off, 3'b000};
        byte_sel   = word[shift +: BYTE_W];
        half_sel   = off[1] ? word[31:16] : word[15:0];
        case (opcode)
            OPCODE_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            OPCODE_LBU: result = {24'h0, byte_sel};
            OPCODE_LH:  result = {{16{half_sel[15]}}, half_sel};
            OPCODE_LHU: result = {16'h0, half_sel};
            OPCODE_LWL: result = (word << shift_left) | (rt_old & (32'h00FF_FFFF >> shift));
            OPCODE_LWR: result = (word >> shift) | (rt_old & ~(32'hFFFF_FFFF >> shift));
            default:    result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_controller.sv
// Data-memory access sequencer for the multi-cycle MIPS core over Avalon-MM.
// Optional misalignment trap enabled by defining MEM_ACCESS_MISALIGN_TRAP_EN.
//
// state  | meaning
// IDLE   | waiting for start with a load/store opcode
// ACCESS | bus command held until waitrequest drops
// DONE   | one-cycle completion, done pulse, commands released
module mem_access_controller
    import mips_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [5:0]              opcode,
    input  logic [31:0]             addr,
    input  logic [31:0]             store_data,
    input  logic [31:0]             rt_old,
    mem_access_controller_if.master avm,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             load_result,
    output logic                    misaligned
);

    localparam logic [1:0] ST_IDLE   = MEM_IDLE;
    localparam logic [1:0] ST_ACCESS = MEM_ACCESS;
    localparam logic [1:0] ST_DONE   = MEM_DONE;

    logic [1:0]  state_q,       state_d;
    logic [5:0]  op_q,          op_d;
    logic [1:0]  off_q,         off_d;
    logic [31:0] rt_old_q,      rt_old_d;
    logic [31:0] address_q,     address_d;
    logic        read_q,        read_d;
    logic        write_q,       write_d;
    logic [3:0]  be_q,          be_d;
    logic [31:0] wdata_q,       wdata_d;
    logic [31:0] load_result_q, load_result_d;
    logic        misaligned_q,  misaligned_d;

    logic        accept;
    logic        trap;
    logic [31:0] ext_word;

    load_extend u_load_extend (
        .word   (avm.avm_readdata),
        .off    (off_q),
        .opcode (op_q),
        .rt_old (rt_old_q),
        .result (ext_word)
    );

    assign accept = start && is_mem_op(opcode);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign trap = (((opcode == OPCODE_LH) || (opcode == OPCODE_LHU) || (opcode == OPCODE_SH)) && addr[0])
               || (((opcode == OPCODE_LW) || (opcode == OPCODE_SW)) && (addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        off_d         = off_q;
        rt_old_d      = rt_old_q;
        address_d     = address_q;
        read_d        = read_q;
        write_d       = write_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        load_result_d = load_result_q;
        misaligned_d  = misaligned_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d     = opcode;
                    off_d    = addr[1:0];
                    rt_old_d = rt_old;
                    if (trap) begin
                        // Faulting access never reaches the bus.
                        state_d      = ST_DONE;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d   = ST_ACCESS;
                        address_d = {addr[31:2], 2'b00};
                        read_d    = !is_store(opcode);
                        write_d   = is_store(opcode);
                        be_d      = lane_enable(opcode, addr[1:0]);
                        wdata_d   = is_store(opcode) ? store_lanes(opcode, store_data) : 32'h0;
                    end
                end
            end
            ST_ACCESS: begin
                if (!avm.avm_waitrequest) begin
                    state_d   = ST_DONE;
                    address_d = 32'h0;
                    read_d    = 1'b0;
                    write_d   = 1'b0;
                    be_d      = 4'h0;
                    wdata_d   = 32'h0;
                    if (!is_store(op_q)) begin
                        load_result_d = ext_word;
                    end
                end
            end
            ST_DONE: begin
                state_d      = ST_IDLE;
                misaligned_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            op_q          <= 6'h0;
            off_q         <= 2'b00;
            rt_old_q      <= 32'h0;
            address_q     <= 32'h0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            be_q          <= 4'h0;
            wdata_q       <= 32'h0;
            load_result_q <= 32'h0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            off_q         <= off_d;
            rt_old_q      <= rt_old_d;
            address_q     <= address_d;
            read_q        <= read_d;
            write_q       <= write_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            load_result_q <= load_result_d;
            misaligned_q  <= misaligned_d;
        end
    end

    assign avm.avm_address    = address_q;
    assign avm.avm_read       = read_q;
    assign avm.avm_write      = write_q;
    assign avm.avm_byteenable = be_q;
    assign avm.avm_writedata  = wdata_q;
    assign busy               = (state_q != ST_IDLE);
    assign done               = (state_q == ST_DONE);
    assign load_result        = load_result_q;
    assign misaligned         = misaligned_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed table-driven bench for mem_access_controller plus hand-written multi-cycle sequences.
module tb_mem_access_controller;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rt;
        logic [31:0] rd;
        int          waits;
        logic        trap;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] res;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] rt_old;
    logic        busy;
    logic        done;
    logic [31:0] load_result;
    logic        misaligned;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model_result;
    vec_t        vecs[12];

    mem_access_controller_if bus ();

    mem_access_controller dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .opcode      (opcode),
        .addr        (addr),
        .store_data  (store_data),
        .rt_old      (rt_old),
        .avm         (bus),
        .busy        (busy),
        .done        (done),
        .load_result (load_result),
        .misaligned  (misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [5:0] op, input logic [31:0] a,
                                input logic [31:0] sd, input logic [31:0] rt, input logic [31:0] rd,
                                input int waits, input logic trap, input logic [3:0] be,
                                input logic [31:0] wd, input logic [31:0] res);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.sd = sd; v.rt = rt; v.rd = rd;
        v.waits = waits; v.trap = trap; v.be = be; v.wd = wd; v.res = res;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int   lat;
        int   acc;
        logic st;
        st = (v.op == 6'h28) || (v.op == 6'h29) || (v.op == 6'h2B);
        @(negedge clk);
        opcode = v.op; addr = v.a; store_data = v.sd; rt_old = v.rt;
        bus.avm_readdata = v.rd; bus.avm_waitrequest = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        acc = 0;
        while (!done && lat < 40) begin
            chk({v.name, " busy"}, {31'h0, busy}, 32'h1);
            chk({v.name, " read"}, {31'h0, bus.avm_read}, {31'h0, !st});
            chk({v.name, " write"}, {31'h0, bus.avm_write}, {31'h0, st});
            chk({v.name, " address"}, bus.avm_address, {v.a[31:2], 2'b00});
            chk({v.name, " be"}, {28'h0, bus.avm_byteenable}, {28'h0, v.be});
            chk({v.name, " wdata"}, bus.avm_writedata, v.wd);
            bus.avm_waitrequest = (acc < v.waits);
            acc++;
            @(negedge clk);
            lat++;
        end
        bus.avm_waitrequest = 1'b0;
        if (!v.trap && !st) model_result = v.res;
        chk({v.name, " latency"}, lat, v.trap ? 32'd1 : v.waits + 2);
        chk({v.name, " done"}, {31'h0, done}, 32'h1);
        chk({v.name, " misaligned"}, {31'h0, misaligned}, {31'h0, v.trap});
        chk({v.name, " cmd released"}, {30'h0, bus.avm_read, bus.avm_write}, 32'h0);
        chk({v.name, " load_result"}, load_result, model_result);
        @(negedge clk);
        chk({v.name, " done pulse"}, {30'h0, done, busy}, 32'h0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; opcode = 6'h0; addr = 32'h0;
        store_data = 32'h0; rt_old = 32'h0;
        bus.avm_readdata = 32'h0; bus.avm_waitrequest = 1'b0;
        model_result = 32'h0;

        vecs[0]  = mk("lb_1003",  6'h20, 32'h0000_1003, 32'h0, 32'h0, 32'h80AA_BBCC, 0, 1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80);
        vecs[1]  = mk("lbu_1003", 6'h24, 32'h0000_1003, 32'h0, 32'h0, 32'h80AA_BBCC, 0, 1'b0, 4'b1000, 32'h0, 32'h0000_0080);
        vecs[2]  = mk("sh_2002",  6'h29, 32'h0000_2002, 32'h1234_BEEF, 32'h0, 32'h0, 3, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        vecs[3]  = mk("lwl_off1", 6'h22, 32'h0000_4001, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 0, 1'b0, 4'b1111, 32'h0, 32'h2211_CCDD);
        vecs[4]  = mk("lwr_off1", 6'h26, 32'h0000_4001, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 0, 1'b0, 4'b1111, 32'h0, 32'hAA44_3322);
        vecs[5]  = mk("lh_5002",  6'h21, 32'h0000_5002, 32'h0, 32'h0, 32'h8001_7FFF, 1, 1'b0, 4'b1100, 32'h0, 32'hFFFF_8001);
        vecs[6]  = mk("lhu_5000", 6'h25, 32'h0000_5000, 32'h0, 32'h0, 32'h8001_7FFF, 0, 1'b0, 4'b0011, 32'h0, 32'h0000_7FFF);
        vecs[7]  = mk("sb_6001",  6'h28, 32'h0000_6001, 32'h0000_00A5, 32'h0, 32'h0, 0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        vecs[8]  = mk("sw_7000",  6'h2B, 32'h0000_7000, 32'hDEAD_BEEF, 32'h0, 32'h0, 2, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        vecs[9]  = mk("lw_8000",  6'h23, 32'h0000_8000, 32'h0, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 4'b1111, 32'h0, 32'hCAFE_F00D);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        vecs[10] = mk("lw_3002",  6'h23, 32'h0000_3002, 32'h0, 32'h0, 32'h1122_3344, 0, 1'b1, 4'b1111, 32'h0, 32'h0);
`else
        vecs[10] = mk("lw_3002",  6'h23, 32'h0000_3002, 32'h0, 32'h0, 32'h1122_3344, 0, 1'b0, 4'b1111, 32'h0, 32'h1122_3344);
`endif
        vecs[11] = mk("lb_1001",  6'h20, 32'h0000_1001, 32'h0, 32'h0, 32'h80AA_BBCC, 0, 1'b0, 4'b0010, 32'h0, 32'hFFFF_FFBB);

        repeat (2) @(negedge clk);
        chk("reset busy/done", {30'h0, busy, done}, 32'h0);
        chk("reset rd/wr", {30'h0, bus.avm_read, bus.avm_write}, 32'h0);
        chk("reset address", bus.avm_address, 32'h0);
        chk("reset be", {28'h0, bus.avm_byteenable}, 32'h0);
        chk("reset wdata", bus.avm_writedata, 32'h0);
        chk("reset load_result", load_result, 32'h0);
        chk("reset misaligned", {31'h0, misaligned}, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Unsupported opcode is ignored.
        @(negedge clk);
        opcode = 6'h08; addr = 32'h0000_0100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("addi ignored", {28'h0, busy, done, bus.avm_read, bus.avm_write}, 32'h0);
            @(negedge clk);
        end

        // Second start during ACCESS is dropped.
        opcode = 6'h23; addr = 32'h0000_9000; bus.avm_readdata = 32'h0102_0304; start = 1'b1;
        @(negedge clk);
        opcode = 6'h2B; addr = 32'h0000_A000; bus.avm_waitrequest = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy start read", {31'h0, bus.avm_read}, 32'h1);
        chk("busy start write", {31'h0, bus.avm_write}, 32'h0);
        chk("busy start address", bus.avm_address, 32'h0000_9000);
        bus.avm_waitrequest = 1'b0;
        @(negedge clk);
        chk("busy start done", {31'h0, done}, 32'h1);
        chk("busy start result", load_result, 32'h0102_0304);
        model_result = 32'h0102_0304;
        @(negedge clk);
        chk("busy start idle", {31'h0, busy}, 32'h0);
        @(negedge clk);
        chk("busy start no retry", {29'h0, busy, bus.avm_read, bus.avm_write}, 32'h0);

        // Asynchronous reset in the middle of an access.
        opcode = 6'h23; addr = 32'h0000_B000; bus.avm_readdata = 32'h7777_7777; start = 1'b1;
        @(negedge clk);
        start = 1'b0; bus.avm_waitrequest = 1'b1;
        chk("pre-reset read", {31'h0, bus.avm_read}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset read", {31'h0, bus.avm_read}, 32'h0);
        chk("async reset busy", {31'h0, busy}, 32'h0);
        chk("async reset result", load_result, 32'h0);
        model_result = 32'h0;
        @(negedge clk);
        reset_n = 1'b1;
        bus.avm_waitrequest = 1'b0;
        run_vec(mk("lw_after_reset", 6'h23, 32'h0000_C004, 32'h0, 32'h0, 32'h5A5A_0001, 1, 1'b0, 4'b1111, 32'h0, 32'h5A5A_0001));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_controller.md
# mem_access_controller

Sequences every data-memory access of the multi-cycle MIPS core over the Avalon-MM data port. It takes the effective address from the ALU (base + sign-extended immediate) and generates byte lanes and store data replication. It holds the request through `avm_waitrequest`, then sign/zero-extends or merges returned load data (LB/LBU/LH/LHU/LW/LWL/LWR) before write-back. It sits between the main control FSM and the bus, and signals completion with a one-cycle `done`.

## Interface
- No parameters (widths fixed by ISA: 32-bit data/address, 6-bit opcode).
- `clk` in 1: single clock, all state updates on rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request from control FSM; sampled only in IDLE.
- `opcode` in 6: instruction opcode, sampled with `start`.
- `addr` in 32: effective byte address, sampled with `start`.
- `store_data` in 32: rt value for stores, sampled with `start`.
- `rt_old` in 32: current rt for LWL/LWR merge, sampled with `start`.
- `avm_address` out 32: word-aligned address (`addr[31:2]`, 2'b00).
- `avm_read` out 1, `avm_write` out 1: Avalon commands.
- `avm_byteenable` out 4: lane enables, bit k = bits 8k+7:8k (little-endian).
- `avm_writedata` out 32: lane-replicated store data.
- `avm_readdata` in 32, `avm_waitrequest` in 1: Avalon response/stall.
- `busy` out 1: high in ACCESS and DONE.
- `done` out 1: one-cycle completion pulse.
- `load_result` out 32: final rt value for loads; held until next accepted load.
- `misaligned` out 1: alignment fault flag, valid with `done`.

## Operation
- States: IDLE, ACCESS, DONE. IDLE→ACCESS on `start` with a supported opcode. ACCESS→DONE on the edge where `avm_waitrequest`=0. DONE→IDLE unconditionally.
- Supported: LB 0x20, LH 0x21, LWL 0x22, LW 0x23, LBU 0x24, LHU 0x25, LWR 0x26, SB 0x28, SH 0x29, SW 0x2B. Other opcodes with `start`: ignored, stay IDLE, no `done`.
- `start` while busy: ignored.
- off = addr[1:0]. Byte ops: be = 1<<off. Half ops: be = off[1] ? 4'b1100 : 4'b0011. Word, LWL, LWR: 4'b1111.
- Store data: SB {4{byte}}, SH {2{half}}, SW as-is. `avm_writedata` = 0 for loads.
- Loads: capture the selected lane on the completing edge. LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW passes the word.
- LWL: (word << 8·(3−off)) | (rt_old & (32'h00FF_FFFF >> 8·off)).
- LWR: (word >> 8·off) | (rt_old & ~(32'hFFFF_FFFF >> 8·off)).
- Stores leave `load_result` unchanged.
- `avm_read`/`avm_write`, address, byteenable and writedata are registered. They are stable throughout ACCESS and deasserted in DONE.

## Timing
- Reset: state IDLE; all outputs 0 (including `load_result`, `misaligned`).
- `start` at edge N → ACCESS cycle N+1 with command asserted. Zero wait → DONE at N+2 with `done`=1 and `load_result` valid. Minimum latency 2 cycles; each waitrequest cycle adds 1.
- `done` lasts exactly one cycle. The earliest next accepted `start` is at the edge leaving DONE (returns to IDLE, sampled next cycle).
- Reset asserted mid-ACCESS: immediate asynchronous return to IDLE, commands dropped. The bus side must tolerate the abandoned transfer.

## Configuration
- `MEM_ACCESS_MISALIGN_TRAP_EN` defined: LH/LHU/SH with addr[0]=1, or LW/SW with off≠0, skip ACCESS. IDLE→DONE directly, no bus command, `misaligned`=1 with `done`, `load_result` unchanged.
- Undefined: no check. The access proceeds with lanes derived from off as above (LW/SW use the aligned word). `misaligned` tied 0.
- LWL/LWR are never trapped.

## Structure
- Shared package `mips_pkg`: OPCODE_* constants (all load/store opcodes above), `mem_state_t` enum, byte-lane width constants.
- Sub-module `load_extend`: combinational lane select, sign/zero extension, and LWL/LWR merge (inputs word, off, opcode, rt_old). The controller instantiates it on the ACCESS-completion path.

## Test plan
- LB at 0x1003, readdata 0x80AA_BBCC, no wait → be 4'b1000, `done` at N+2, `load_result` 0xFFFF_FF80. LBU same → 0x0000_0080.
- SH at 0x2002, store_data 0x1234_BEEF, waitrequest high 3 cycles → be 4'b1100, writedata 0xBEEF_BEEF held 4 ACCESS cycles, `done` at N+5.
- LWL off=1, word 0x4433_2211, rt_old 0xAABB_CCDD → 0x2211_CCDD. LWR off=1 same inputs → 0xAA44_3322.
- `start` with opcode 0x08 (ADDI) → stays IDLE, no command, no `done`. `start` during ACCESS → ignored.
- Macro defined, LW at 0x3002 → no `avm_read`, `done` at N+1 with `misaligned`=1. Macro undefined → read at 0x3000, be 4'b1111.
- `reset_n` low mid-ACCESS → `avm_read`, `busy` 0 immediately. After release, a fresh LW completes normally.
